// File: rtl/mlt_pkg.sv
// Shared MLT-3 definitions for the line encoder (mlt_enc) and its matching decoder.
// Contents: symbol encoding, the four-state level phase, the encoder FSM states, and helpers
// that advance the phase and map a phase to its line symbol.
package mlt_pkg;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_POS  = 2'b01,
        SYM_NEG  = 2'b10,
        SYM_ERR  = 2'b11
    } mlt_sym_e;

    // P0Z and P0N both drive 0 and differ only in which level comes next.
    typedef enum logic [1:0] {
        P0Z = 2'd0,
        PP  = 2'd1,
        P0N = 2'd2,
        PN  = 2'd3
    } mlt_phase_e;

    typedef enum logic {
        StIdle,
        StShift
    } enc_state_e;

    function automatic mlt_phase_e next_phase(input mlt_phase_e p);
        mlt_phase_e n;
        n = P0Z;
        unique case (p)
            P0Z: n = PP;
            PP:  n = P0N;
            P0N: n = PN;
            PN:  n = P0Z;
            default: n = P0Z;
        endcase
        return n;
    endfunction

    function automatic mlt_sym_e phase_sym(input mlt_phase_e p);
        mlt_sym_e s;
        s = SYM_ZERO;
        unique case (p)
            P0Z: s = SYM_ZERO;
            PP:  s = SYM_POS;
            P0N: s = SYM_ZERO;
            PN:  s = SYM_NEG;
            default: s = SYM_ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mlt_level_fsm.sv
// MLT-3 level generator: holds the line phase and steps it on each 'adv'.
// The symbol is registered from the next phase so the line output has no
// combinational path from any input.
// Ports:
//   clk  in   clock, all state on posedge
//   rst  in   synchronous active-high reset (phase P0Z, symbol 00)
//   adv  in   advance the phase one step this cycle
//   sym  out  registered line symbol for the current phase
module mlt_level_fsm
    import mlt_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     adv,
    output mlt_sym_e sym
);

    mlt_phase_e phase_q, phase_d;
    mlt_sym_e   sym_q;

    always_comb begin
        phase_d = phase_q;
        if (adv) begin
            phase_d = next_phase(phase_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= P0Z;
            sym_q   <= SYM_ZERO;
        end else begin
            phase_q <= phase_d;
            sym_q   <= phase_sym(phase_d);
        end
    end

    assign sym = sym_q;

endmodule

// File: rtl/mlt_enc.sv
// MLT-3 line encoder: serializes DATA_W-bit words and encodes each bit onto a 2-bit symbol bus.
// A 1 bit steps the line level through 0,+,0,-; a 0 bit holds it. Words can be chained with no
// idle symbols: in_ready rises during the last-bit cycle of the word in flight.
// Optional feature macro: MLT_ENC_ERR_INJECT_EN adds force_err, which replaces the symbol of
// that cycle with 2'b11 without disturbing the bit stream.
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-high reset; drops any word in flight
//   force_err  in   (MLT_ENC_ERR_INJECT_EN only) emit 2'b11 for this cycle
//   in_data    in   word to transmit
//   in_valid   in   in_data valid
//   in_ready   out  word accepted this cycle when in_valid is also high
//   out        out  line symbol: 00 = 0, 01 = +1, 10 = -1, 11 = injected error
//   busy       out  word in flight
module mlt_enc
    import mlt_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MLT_ENC_ERR_INJECT_EN
    input  logic              force_err,
`endif
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [1:0]        out,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(DATA_W);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

    enc_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              xfer;
    logic              cur_bit;
    logic              adv;
    mlt_sym_e          sym;

    // cnt is 0 whenever idle, so one compare covers both ready cases.
    assign in_ready = (state_q == StIdle) || (cnt_q == '0);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state_q == StShift);
    assign cur_bit  = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        adv     = 1'b0;
        if (state_q == StShift) begin
            adv     = cur_bit;
            shreg_d = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};
            cnt_d   = cnt_q - CntW'(1);
            if (cnt_q == '0) begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        end
        // A transfer during the last bit reloads straight away for back-to-back words.
        if (xfer) begin
            shreg_d = in_data;
            cnt_d   = CntLast;
            state_d = StShift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    mlt_level_fsm u_level (
        .clk (clk),
        .rst (rst),
        .adv (adv),
        .sym (sym)
    );

`ifdef MLT_ENC_ERR_INJECT_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= force_err;
        end
    end

    // Error overlay sits after the level register, so phase keeps tracking the real data.
    assign out = err_q ? SYM_ERR : sym;
`else
    assign out = sym;
`endif

endmodule
